tt_lu_arbiter: RTL and testbench
================================

Name: tt_lu_arbiter

Overview:
Shares one 8-bit logic unit (NOT/AND/OR/XOR) between two requesters. Each requester has its own valid/ready request channel and response channel. Grants are round-robin. The unit accepts one operation at a time, registers the result, and holds it until the owning requester takes it. The block sits between the pin-level I/O capture logic and the logic unit inside the tt_um_* top.

Parameters:
- W, 8, operand/result width in bits.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  2  opcode: 00 NOT a, 01 a AND b, 10 a OR b, 11 a XOR b
- req0_a  in  W  operand a
- req0_b  in  W  operand b (ignored for NOT)
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes the result
- rsp0_data  out  W  result for requester 0
- rsp1_valid, rsp1_ready, rsp1_data  same as requester 0, for requester 1
- busy  out  1  high when state is not IDLE
- stat0_cnt  out  8  completed ops for requester 0 (optional feature)
- stat1_cnt  out  8  completed ops for requester 1 (optional feature)

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, prio=0 (requester 0 favoured)
  - all ready/valid outputs 0, rsp*_data=0, busy=0, stat counters 0
  - reset mid-operation abandons the op; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = requester holding prio if its valid=1, else the other if its valid=1.
  - req{grant}_ready=1 combinationally in the same cycle; the non-granted ready is 0.
  - On the edge: latch op/a/b and owner=grant; go to EXEC.
  - No valid: stay in IDLE; all readys 0.
- EXEC (1 cycle):
  - result register <= f(op,a,b), truncated to W bits; go to RESP.
  - All readys 0.
- RESP:
  - rsp{owner}_valid=1 and rsp{owner}_data=result; the other rsp_valid=0 and its data holds its last value.
  - Valid and data stay stable until rsp{owner}_ready=1.
  - On the handshake edge: go to IDLE and set prio = ~owner.
  - No new request is accepted while in RESP.
- Latency: accept edge -> rsp_valid high 2 cycles later. Minimum issue interval 3 cycles (accept, exec, resp with ready=1).
- Both valid in the same IDLE cycle: prio wins. After that completion prio flips, so the other requester wins next.
- A requester may drop valid before it is granted; nothing is latched for it.
- rsp_ready while rsp_valid=0 is ignored.
- Operand changes after acceptance do not affect the result.
- busy = (state != IDLE).

Optional Feature:
- Macro: TT_LU_ARB_STATS_EN.
- Defined:
  - stat{owner}_cnt increments on each response handshake.
  - Saturates at 8'hFF; no wrap.
- Undefined:
  - stat0_cnt and stat1_cnt are tied to 0.
  - No counter flops are synthesised.
  - Ports remain present so the interface is unchanged.

Decomposition:
- Package tt_lu_pkg:
  - opcode enum (OP_NOT=0, OP_AND=1, OP_OR=2, OP_XOR=3)
  - FSM state enum (IDLE, EXEC, RESP)
  - STAT_W=8
- Sub-module tt_logic_unit: purely combinational f(op,a,b), parameter W. It is instantiated once.
- Arbitration, FSM and response muxing stay in tt_lu_arbiter.

Test Plan:
- Reset then single op:
  - Stimulus: req0 op=00, a=8'h3C.
  - Required: req0_ready=1 at cycle 0; rsp0_valid=1 at cycle 2 with data=8'hC3; with rsp0_ready=1, busy drops the next cycle.
- All ops from requester 1 with a=8'hF0, b=8'h3C:
  - Required: AND -> 8'h30, OR -> 8'hFC, XOR -> 8'hCC.
  - Required: rsp0_valid stays 0 throughout.
- Contention, both valid continuously:
  - Required: grant order 0,1,0,1.
  - Required: ready never high for both in one cycle.
  - Required: each response goes only to its owner.
- Backpressure:
  - Stimulus: rsp0_ready=0 for 5 cycles while in RESP.
  - Required: rsp0_valid/data stable; req1_ready stays 0; completion occurs on the first ready=1 cycle.
- Reset mid-operation:
  - Stimulus: rst=1 during EXEC.
  - Required: next cycle state IDLE; no rsp_valid; prio=0.
- With TT_LU_ARB_STATS_EN:
  - 300 req0 ops -> stat0_cnt=8'hFF and stat1_cnt=0.
  - Without the macro, both counters read 0.

Source files
------------

// File: rtl/tt_lu_pkg.sv
// rtl/tt_lu_pkg.sv - shared opcode/state types and widths for the logic-unit arbiter
package tt_lu_pkg;

  localparam int STAT_W = 8;

  typedef enum logic [1:0] {
    OP_NOT = 2'd0,
    OP_AND = 2'd1,
    OP_OR  = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/tt_logic_unit.sv
// rtl/tt_logic_unit.sv - combinational NOT/AND/OR/XOR unit shared by both requesters
module tt_logic_unit
  import tt_lu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);

  // Select the bitwise function; operand b is ignored for NOT.
  always_comb begin
    o_y = '0;
    case (op_e'(i_op))
      OP_NOT:  o_y = ~i_a;
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/tt_lu_arbiter.sv
// rtl/tt_lu_arbiter.sv - round-robin arbiter sharing one logic unit; TT_LU_ARB_STATS_EN adds per-requester completion counters
module tt_lu_arbiter
  import tt_lu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [W-1:0]      req0_a,
  input  logic [W-1:0]      req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [W-1:0]      req1_a,
  input  logic [W-1:0]      req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [W-1:0]      rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [W-1:0]      rsp1_data,
  output logic              busy,
  output logic [STAT_W-1:0] stat0_cnt,
  output logic [STAT_W-1:0] stat1_cnt
);

  state_e       r_state;
  logic         r_prio;
  logic         r_owner;
  logic [1:0]   r_op;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_rsp0_valid;
  logic         r_rsp1_valid;
  logic [W-1:0] r_rsp0_data;
  logic [W-1:0] r_rsp1_data;

  logic         w_any_valid;
  logic         w_grant;
  logic         w_rsp_hs;
  logic [W-1:0] w_result;

  // Favour the prio holder when it is valid, otherwise fall back to the other requester.
  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    w_grant     = r_prio ? req1_valid : ~req0_valid;
    w_rsp_hs    = (r_state == RESP) && (r_owner ? rsp1_ready : rsp0_ready);
  end

  assign req0_ready = (r_state == IDLE) && w_any_valid && !w_grant;
  assign req1_ready = (r_state == IDLE) && w_any_valid &&  w_grant;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_data  = r_rsp0_data;
  assign rsp1_data  = r_rsp1_data;
  assign busy       = (r_state != IDLE);

  tt_logic_unit #(.W(W)) u_lu (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_result)
  );

  // Accept -> execute into the owner's response register -> hold until the owner takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prio       <= 1'b0;
      r_owner      <= 1'b0;
      r_op         <= 2'd0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp1_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_owner <= w_grant;
            r_op    <= w_grant ? req1_op : req0_op;
            r_a     <= w_grant ? req1_a  : req0_a;
            r_b     <= w_grant ? req1_b  : req0_b;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (r_owner) begin
            r_rsp1_data  <= w_result;
            r_rsp1_valid <= 1'b1;
          end else begin
            r_rsp0_data  <= w_result;
            r_rsp0_valid <= 1'b1;
          end
          r_state <= RESP;
        end
        RESP: begin
          if (w_rsp_hs) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_prio       <= ~r_owner;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef TT_LU_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat0;
  logic [STAT_W-1:0] r_stat1;

  // Count completed handshakes per owner, saturating instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat0 <= '0;
      r_stat1 <= '0;
    end else if (w_rsp_hs) begin
      if (!r_owner && (r_stat0 != '1)) r_stat0 <= r_stat0 + 1'b1;
      if ( r_owner && (r_stat1 != '1)) r_stat1 <= r_stat1 + 1'b1;
    end
  end

  assign stat0_cnt = r_stat0;
  assign stat1_cnt = r_stat1;
`else
  assign stat0_cnt = '0;
  assign stat1_cnt = '0;
`endif

endmodule

// File: tb/tb_tt_lu_arbiter.sv
// tb/tb_tt_lu_arbiter.sv - scoreboard bench for tt_lu_arbiter
module tb_tt_lu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready, rsp1_ready;
  logic [7:0] rsp0_data, rsp1_data;
  logic       busy;
  logic [7:0] stat0_cnt, stat1_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] sb[$];
  int         grant_log[$];
  bit         seen_rsp0;

  always #5 clk = ~clk;

  tt_lu_arbiter #(.W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .busy(busy), .stat0_cnt(stat0_cnt), .stat1_cnt(stat1_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return ~a;
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic pop_cmp(input logic id, input logic [7:0] data);
    logic [8:0] e;
    if (sb.size() == 0) begin
      chk("sb_pop_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("rsp_owner", {31'd0, id}, {31'd0, e[8]});
      chk("rsp_data", {24'd0, data}, {24'd0, e[7:0]});
    end
  endtask

  // Monitor: push expectations on accept, compare on response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_ready && req1_ready) chk("ready_both", 1, 0);
      if (rsp0_valid && rsp1_valid) chk("rsp_both", 1, 0);
      if (req0_valid && req0_ready) begin
        sb.push_back({1'b0, model(req0_op, req0_a, req0_b)});
        grant_log.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back({1'b1, model(req1_op, req1_a, req1_b)});
        grant_log.push_back(1);
      end
      if (rsp0_valid) seen_rsp0 = 1'b1;
      if (rsp0_valid && rsp0_ready) pop_cmp(1'b0, rsp0_data);
      if (rsp1_valid && rsp1_ready) pop_cmp(1'b1, rsp1_data);
    end
  end

  task automatic drive(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else         begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
  endtask

  task automatic wait_ready(input int id);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((id == 0) ? req0_ready : req1_ready) && n < 50);
    if (!((id == 0) ? req0_ready : req1_ready)) chk("timeout_ready", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 50);
    if (busy) chk("timeout_idle", 1, 0);
  endtask

  // Returns just after the accept edge, with the DUT in EXEC.
  task automatic issue(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    drive(id, op, a, b);
    wait_ready(id);
    @(posedge clk); #1;
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] t2_exp[3];
    int         exp_order[4];
    int         n;
    t2_exp[0] = 8'h30; t2_exp[1] = 8'hFC; t2_exp[2] = 8'hCC;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;

    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_data", rsp0_data, 0);
    chk("rst_rsp1_data", rsp1_data, 0);
    chk("rst_stat0", stat0_cnt, 0);
    chk("rst_stat1", stat1_cnt, 0);

    // Single NOT op with cycle-accurate latency
    @(posedge clk); #1;
    drive(0, 2'd0, 8'h3C, 8'h00);
    @(negedge clk);
    chk("single_ready_c0", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("single_busy_c1", busy, 1);
    chk("single_rsp_c1", rsp0_valid, 0);
    @(negedge clk);
    chk("single_rsp_c2", rsp0_valid, 1);
    chk("single_data_c2", rsp0_data, 8'hC3);
    @(negedge clk);
    chk("single_busy_after", busy, 0);

    // All binary ops from requester 1
    seen_rsp0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(1, 2'(i + 1), 8'hF0, 8'h3C);
      @(negedge clk);
      @(negedge clk);
      chk("r1_rsp_valid", rsp1_valid, 1);
      chk("r1_rsp_data", rsp1_data, t2_exp[i]);
      wait_idle();
    end
    chk("r1_no_rsp0", seen_rsp0, 0);

    // Contention: both valid continuously
    grant_log.delete();
    @(posedge clk); #1;
    drive(0, 2'd1, 8'hAA, 8'h0F);
    drive(1, 2'd2, 8'h11, 8'h22);
    n = 0;
    while (grant_log.size() < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    if (grant_log.size() < 4) chk("cont_timeout", grant_log.size(), 4);
    else for (int i = 0; i < 4; i++) chk("cont_order", grant_log[i], exp_order[i]);
    wait_idle();

    // Backpressure on requester 0 with requester 1 waiting
    rsp0_ready = 1'b0;
    @(posedge clk); #1;
    drive(0, 2'd3, 8'h5A, 8'hFF);
    wait_ready(0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drive(1, 2'd0, 8'h0F, 8'h00);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp0_valid && n < 20);
    chk("bp_rsp_valid", rsp0_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", rsp0_valid, 1);
      chk("bp_data_hold", rsp0_data, 8'hA5);
      chk("bp_req1_blocked", req1_ready, 0);
    end
    @(posedge clk); #1 rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_busy_before_hs", busy, 1);
    @(negedge clk);
    chk("bp_idle_after_hs", busy, 0);
    chk("bp_req1_granted", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_idle();

    // Reset during EXEC
    issue(0, 2'd1, 8'hFF, 8'h0F);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_busy", busy, 0);
      chk("mrst_rsp0_valid", rsp0_valid, 0);
      chk("mrst_rsp1_valid", rsp1_valid, 0);
    end
    chk("mrst_rsp0_data", rsp0_data, 0);
    @(posedge clk); #1;
    drive(0, 2'd2, 8'h01, 8'h80);
    drive(1, 2'd2, 8'h02, 8'h40);
    @(negedge clk);
    chk("mrst_prio0_r0", req0_ready, 1);
    chk("mrst_prio0_r1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    wait_idle();

    // Statistics counters
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 300; i++)
      issue(0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    wait_idle();
`ifdef TT_LU_ARB_STATS_EN
    chk("stat0_sat", stat0_cnt, 8'hFF);
    chk("stat1_zero", stat1_cnt, 0);
`else
    chk("stat0_off", stat0_cnt, 0);
    chk("stat1_off", stat1_cnt, 0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
